// File: rtl/axi4l_manager_seq.sv
// axi4l_manager_seq
//   AXI4-Lite manager that turns simple request/response streams into AXI4-Lite
//   transactions. The write and read engines are independent, and each allows
//   up to MAX_OUT transactions in flight.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width (multiple of 8); strobe width is DATA_W/8
//   MAX_OUT     outstanding transactions per direction (1..15)
//   TIMEOUT_CYC watchdog limit in cycles (used only with AXI4L_MGR_TIMEOUT_EN)
//
// Ports
//   ACLK, ARESETn               clock, asynchronous active-low reset
//   AW*/W*/B*                   AXI4-Lite write channels (manager side)
//   AR*/R*                      AXI4-Lite read channels (manager side)
//   wr_req_* / wr_rsp_*         user write request / response
//   rd_req_* / rd_rsp_*         user read request / response
//   proto_err                   sticky flag: B or R seen with nothing outstanding
//   timeout_err                 sticky watchdog flag (only with AXI4L_MGR_TIMEOUT_EN)
//
// Build option
//   AXI4L_MGR_TIMEOUT_EN        adds the per-engine watchdogs and the timeout_err port
module axi4l_manager_seq #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // AXI write address / data / response
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  // AXI read address / data
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  // user write side
  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                wr_rsp_valid,
  output logic [1:0]          wr_rsp_resp,
  // user read side
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_rsp_valid,
  output logic [DATA_W-1:0]   rd_rsp_data,
  output logic [1:0]          rd_rsp_resp,
  output logic                proto_err
`ifdef AXI4L_MGR_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  if (MAX_OUT < 1 || MAX_OUT > 15 || TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_param_chk
    $error("axi4l_manager_seq: illegal parameter value");
  end

  localparam int              CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } eng_state_t;

  eng_state_t       wr_state, rd_state;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  logic wr_acc, rd_acc;
  logic b_hs, r_hs;
  logic wr_rsp_ok, rd_rsp_ok;
  logic aw_pend, w_pend, ar_pend;

  // Ready is derived from registers only, so it never depends on same-cycle inputs.
  assign wr_req_ready = !AWVALID && !WVALID && (wr_cnt < CNT_MAX);
  assign rd_req_ready = !ARVALID && (rd_cnt < CNT_MAX);

  assign wr_acc    = wr_req_valid && wr_req_ready;
  assign rd_acc    = rd_req_valid && rd_req_ready;
  assign b_hs      = BVALID && BREADY;
  assign r_hs      = RVALID && RREADY;
  // A response only counts when something is outstanding; otherwise it is a protocol error.
  assign wr_rsp_ok = b_hs && (wr_cnt != '0);
  assign rd_rsp_ok = r_hs && (rd_cnt != '0);

  // VALIDs still waiting for their handshake after this cycle.
  assign aw_pend = AWVALID && !AWREADY;
  assign w_pend  = WVALID && !WREADY;
  assign ar_pend = ARVALID && !ARREADY;

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state <= ST_IDLE;
      AWVALID  <= 1'b0;
      WVALID   <= 1'b0;
      AWADDR   <= '0;
      WDATA    <= '0;
      WSTRB    <= '0;
    end else begin
      case (wr_state)
        ST_IDLE: begin
          if (wr_acc) begin
            AWVALID  <= 1'b1;
            WVALID   <= 1'b1;
            AWADDR   <= wr_addr;
            WDATA    <= wr_data;
            WSTRB    <= wr_strb;
            wr_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          AWVALID <= aw_pend;
          WVALID  <= w_pend;
          if (!aw_pend && !w_pend) begin
            wr_state <= ST_IDLE;
          end
        end
        default: wr_state <= ST_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= ST_IDLE;
      ARVALID  <= 1'b0;
      ARADDR   <= '0;
    end else begin
      case (rd_state)
        ST_IDLE: begin
          if (rd_acc) begin
            ARVALID  <= 1'b1;
            ARADDR   <= rd_addr;
            rd_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ARVALID <= ar_pend;
          if (!ar_pend) begin
            rd_state <= ST_IDLE;
          end
        end
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------- outstanding counters, responses
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      BREADY       <= 1'b0;
      RREADY       <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      wr_rsp_valid <= 1'b0;
      wr_rsp_resp  <= '0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_resp  <= '0;
      proto_err    <= 1'b0;
    end else begin
      BREADY <= 1'b1;
      RREADY <= 1'b1;

      if (wr_acc && !wr_rsp_ok) begin
        wr_cnt <= wr_cnt + CNT_ONE;
      end else if (!wr_acc && wr_rsp_ok) begin
        wr_cnt <= wr_cnt - CNT_ONE;
      end

      if (rd_acc && !rd_rsp_ok) begin
        rd_cnt <= rd_cnt + CNT_ONE;
      end else if (!rd_acc && rd_rsp_ok) begin
        rd_cnt <= rd_cnt - CNT_ONE;
      end

      wr_rsp_valid <= wr_rsp_ok;
      if (wr_rsp_ok) begin
        wr_rsp_resp <= BRESP;
      end

      rd_rsp_valid <= rd_rsp_ok;
      if (rd_rsp_ok) begin
        rd_rsp_data <= RDATA;
        rd_rsp_resp <= RRESP;
      end

      if ((b_hs && wr_cnt == '0) || (r_hs && rd_cnt == '0)) begin
        proto_err <= 1'b1;
      end
    end
  end

`ifdef AXI4L_MGR_TIMEOUT_EN
  // --------------------------------------------------------------- watchdogs
  localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  logic [WD_W-1:0] wr_wd, rd_wd;
  logic            wr_wd_hit, rd_wd_hit;

  // Flag on the same edge the counter reaches the limit, and keep it once there.
  assign wr_wd_hit = (wr_wd == WD_MAX) ||
                     (!wr_rsp_ok && wr_cnt != '0 && wr_wd == WD_MAX - WD_ONE);
  assign rd_wd_hit = (rd_wd == WD_MAX) ||
                     (!rd_rsp_ok && rd_cnt != '0 && rd_wd == WD_MAX - WD_ONE);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_wd       <= '0;
      rd_wd       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wr_rsp_ok) begin
        wr_wd <= '0;
      end else if (wr_cnt != '0 && wr_wd != WD_MAX) begin
        wr_wd <= wr_wd + WD_ONE;
      end

      if (rd_rsp_ok) begin
        rd_wd <= '0;
      end else if (rd_cnt != '0 && rd_wd != WD_MAX) begin
        rd_wd <= rd_wd + WD_ONE;
      end

      if (wr_wd_hit || rd_wd_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi4l_manager_seq.sv
// tb_axi4l_manager_seq
//   Directed, self-checking bench for axi4l_manager_seq (MAX_OUT=4, TIMEOUT_CYC=16).
//   Watchdog checks are compiled in only when AXI4L_MGR_TIMEOUT_EN is defined.
module tb_axi4l_manager_seq;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              AWVALID, AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              WVALID, WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID, BREADY;
  logic [1:0]        BRESP;
  logic              ARVALID, ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RVALID, RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_rsp_valid;
  logic [1:0]        wr_rsp_resp;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_rsp_data;
  logic [1:0]        rd_rsp_resp;
  logic              proto_err;
`ifdef AXI4L_MGR_TIMEOUT_EN
  logic              timeout_err;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi4l_manager_seq #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_OUT     (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .AWADDR       (AWADDR),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .BRESP        (BRESP),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .ARADDR       (ARADDR),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .wr_rsp_valid (wr_rsp_valid),
    .wr_rsp_resp  (wr_rsp_resp),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_resp  (rd_rsp_resp),
    .proto_err    (proto_err)
`ifdef AXI4L_MGR_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    wr_req_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_req_valid = 1'b0; rd_addr = '0;

    // ---- reset values
    #12;
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_bready", BREADY, 0);
    check("rst_rready", RREADY, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_wr_rsp_valid", wr_rsp_valid, 0);
    check("rst_rd_rsp_valid", rd_rsp_valid, 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_rd_rsp_data", rd_rsp_data, 0);
`ifdef AXI4L_MGR_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    ARESETn = 1'b1;
    tick();
    check("post_rst_bready", BREADY, 1);
    check("post_rst_rready", RREADY, 1);
    check("post_rst_wr_req_ready", wr_req_ready, 1);
    check("post_rst_rd_req_ready", rd_req_ready, 1);

    // ---- single write, both channels ready
    AWREADY = 1'b1; WREADY = 1'b1;
    wr_addr = 32'h10; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    check("w1_awvalid", AWVALID, 1);
    check("w1_wvalid", WVALID, 1);
    check("w1_awaddr", AWADDR, 64'h10);
    check("w1_wdata", WDATA, 64'hDEADBEEF);
    check("w1_wstrb", WSTRB, 64'hF);
    check("w1_req_ready_busy", wr_req_ready, 0);
    tick();
    check("w1_awvalid_drop", AWVALID, 0);
    check("w1_wvalid_drop", WVALID, 0);
    check("w1_req_ready_back", wr_req_ready, 1);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("w1_rsp_valid", wr_rsp_valid, 1);
    check("w1_rsp_resp", wr_rsp_resp, 0);
    check("w1_proto_err", proto_err, 0);
    tick();
    check("w1_rsp_pulse_end", wr_rsp_valid, 0);

    // ---- write with W accepted three cycles after AW
    AWREADY = 1'b1; WREADY = 1'b0;
    wr_addr = 32'h24; wr_data = 32'h12345678; wr_strb = 4'h3; wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    check("w2_awvalid", AWVALID, 1);
    tick();
    check("w2_awvalid_drop", AWVALID, 0);
    check("w2_wvalid_held", WVALID, 1);
    check("w2_req_ready_wait", wr_req_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("w2_wvalid_stall", WVALID, 1);
      check("w2_wdata_stable", WDATA, 64'h12345678);
      check("w2_wstrb_stable", WSTRB, 64'h3);
      check("w2_req_ready_stall", wr_req_ready, 0);
    end
    WREADY = 1'b1;
    tick();
    check("w2_wvalid_drop", WVALID, 0);
    check("w2_req_ready_back", wr_req_ready, 1);
    BVALID = 1'b1; BRESP = 2'b10;
    tick();
    BVALID = 1'b0;
    check("w2_rsp_valid", wr_rsp_valid, 1);
    check("w2_rsp_resp", wr_rsp_resp, 2);
    tick();
    check("w2_rsp_pulse_end", wr_rsp_valid, 0);

    // ---- unsolicited B with nothing outstanding
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("ub_no_rsp", wr_rsp_valid, 0);
    check("ub_proto_err", proto_err, 1);
    tick();
    tick();
    check("ub_proto_err_sticky", proto_err, 1);
    check("ub_cnt_no_wrap", wr_req_ready, 1);

    // ---- fill the read side to MAX_OUT, then release one slot
    ARREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 32'h100 + 32'(4 * i);
      rd_req_valid = 1'b1;
      tick();
      rd_req_valid = 1'b0;
      check("rd_arvalid", ARVALID, 1);
      check("rd_araddr", ARADDR, 64'h100 + 64'(4 * i));
      tick();
      check("rd_arvalid_drop", ARVALID, 0);
    end
    check("rd_full_ready", rd_req_ready, 0);
    rd_addr = 32'h200; rd_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_full_blocked", rd_req_ready, 0);
      check("rd_full_no_ar", ARVALID, 0);
    end
    RVALID = 1'b1; RDATA = 32'hA5; RRESP = 2'b00;
    tick();
    RVALID = 1'b0;
    check("rd_rsp_valid", rd_rsp_valid, 1);
    check("rd_rsp_data", rd_rsp_data, 64'hA5);
    check("rd_rsp_resp", rd_rsp_resp, 0);
    check("rd_slot_free", rd_req_ready, 1);
    tick();
    rd_req_valid = 1'b0;
    check("rd5_arvalid", ARVALID, 1);
    check("rd5_araddr", ARADDR, 64'h200);
    check("rd_rsp_pulse_end", rd_rsp_valid, 0);
    tick();
    check("rd5_full_again", rd_req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      RVALID = 1'b1; RDATA = 32'h1000 + 32'(i); RRESP = 2'(i);
      tick();
      RVALID = 1'b0;
      check("drain_rsp_valid", rd_rsp_valid, 1);
      check("drain_rsp_data", rd_rsp_data, 64'h1000 + 64'(i));
      check("drain_rsp_resp", rd_rsp_resp, 64'(i % 4));
      tick();
    end
    check("drain_ready", rd_req_ready, 1);

`ifdef AXI4L_MGR_TIMEOUT_EN
    // ---- watchdog: read never answered, limit 16 cycles
    check("wd_clear_before", timeout_err, 0);
    rd_addr = 32'h300; rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    repeat (15) tick();
    check("wd_before_limit", timeout_err, 0);
    tick();
    check("wd_at_limit", timeout_err, 1);
    tick();
    check("wd_sticky", timeout_err, 1);
`endif

    // ---- reset while a write and a read are stuck in flight
    AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
    wr_addr = 32'h40; wr_data = 32'hCAFEF00D; wr_strb = 4'hC; wr_req_valid = 1'b1;
    rd_addr = 32'h44; rd_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    tick();
    check("mf_awvalid_held", AWVALID, 1);
    check("mf_arvalid_held", ARVALID, 1);
    #2;
    ARESETn = 1'b0;
    #1;
    check("mf_rst_awvalid", AWVALID, 0);
    check("mf_rst_wvalid", WVALID, 0);
    check("mf_rst_arvalid", ARVALID, 0);
    check("mf_rst_bready", BREADY, 0);
    check("mf_rst_rready", RREADY, 0);
    check("mf_rst_proto_err", proto_err, 0);
    check("mf_rst_awaddr", AWADDR, 0);
    check("mf_rst_wdata", WDATA, 0);
    check("mf_rst_wstrb", WSTRB, 0);
    check("mf_rst_araddr", ARADDR, 0);
    check("mf_rst_rd_rsp_data", rd_rsp_data, 0);
`ifdef AXI4L_MGR_TIMEOUT_EN
    check("mf_rst_timeout_err", timeout_err, 0);
`endif
    tick();
    ARESETn = 1'b1;
    tick();
    check("mf_post_bready", BREADY, 1);
    check("mf_post_wr_ready", wr_req_ready, 1);
    check("mf_post_rd_ready", rd_req_ready, 1);
    // Responses to pre-reset requests must be treated as unsolicited.
    BVALID = 1'b1; RVALID = 1'b1; RDATA = 32'h77;
    tick();
    BVALID = 1'b0; RVALID = 1'b0;
    check("mf_stale_no_wr_rsp", wr_rsp_valid, 0);
    check("mf_stale_no_rd_rsp", rd_rsp_valid, 0);
    check("mf_stale_proto_err", proto_err, 1);
    check("mf_stale_rd_data", rd_rsp_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4l_manager_seq.md
AXI4L_MANAGER_SEQ -- requirements
Module: axi4l_manager_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AWADDR/ARADDR width.
REQ-002 SHALL have parameter DATA_W, default 32: WDATA/RDATA width, a multiple of 8; WSTRB width DATA_W/8.
REQ-003 SHALL have parameter MAX_OUT, default 4, range 1..15: maximum outstanding transactions per direction.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 256: watchdog limit in cycles.
REQ-005 SHALL have ports:
- ACLK in 1: single clock.
- ARESETn in 1: reset, asynchronous, active-low.
- AWVALID/AWREADY out/in 1; AWADDR out ADDR_W.
- WVALID/WREADY out/in 1; WDATA out DATA_W; WSTRB out DATA_W/8.
- BVALID in 1; BREADY out 1; BRESP in 2.
- ARVALID/ARREADY out/in 1; ARADDR out ADDR_W.
- RVALID in 1; RREADY out 1; RDATA in DATA_W; RRESP in 2.
- wr_req_valid/wr_req_ready in/out 1; wr_addr in ADDR_W; wr_data in DATA_W; wr_strb in DATA_W/8.
- wr_rsp_valid out 1; wr_rsp_resp out 2.
- rd_req_valid/rd_req_ready in/out 1; rd_addr in ADDR_W.
- rd_rsp_valid out 1; rd_rsp_data out DATA_W; rd_rsp_resp out 2.
- proto_err out 1: sticky flag for an unexpected B or R.
- timeout_err out 1: sticky watchdog flag, present only with the macro.

Function
REQ-006 SHALL accept a write request when wr_req_valid && wr_req_ready, and latch addr/data/strb into the AW and W output registers.
REQ-007 SHALL assert AWVALID and WVALID on the cycle after acceptance; each SHALL drop independently on its own handshake; payload SHALL be held stable while VALID is high.
REQ-008 SHALL drive wr_req_ready = !AWVALID && !WVALID && (wr_cnt < MAX_OUT), combinationally from registers only.
REQ-009 SHALL keep wr_cnt, width $clog2(MAX_OUT+1): +1 on request accept, -1 on B handshake, unchanged when both occur in the same cycle.
REQ-010 SHALL drive BREADY=1 whenever out of reset; on BVALID with wr_cnt>0, SHALL pulse wr_rsp_valid for one cycle (registered, 1-cycle latency) with wr_rsp_resp=BRESP.
REQ-011 Read path SHALL mirror REQ-006..010: AR register, rd_cnt, rd_req_ready = !ARVALID && (rd_cnt < MAX_OUT), RREADY=1, rd_rsp_valid pulse with RDATA/RRESP registered.
REQ-012 Write and read engines SHALL run independently and concurrently; there is no ordering between directions.
REQ-013 A BVALID with wr_cnt==0, or an RVALID with rd_cnt==0, SHALL be ignored (no rsp pulse, no counter change) and SHALL set proto_err.
REQ-014 A counter SHALL never wrap: MAX_OUT blocks accept; 0 blocks decrement per REQ-013.
REQ-015 Each engine SHALL be a 2-state FSM: IDLE (no VALID pending) and ISSUE (VALID pending); ISSUE returns to IDLE when all of its VALIDs have handshaked.

Reset
REQ-016 ARESETn low SHALL asynchronously clear all VALIDs, counters, rsp_valid pulses, proto_err and timeout_err; AWADDR/WDATA/WSTRB/ARADDR/rd_rsp_data SHALL reset to 0 and BREADY/RREADY to 0.
REQ-017 Reset mid-transaction SHALL discard all outstanding state; no response SHALL be emitted for pre-reset requests.
REQ-018 BREADY/RREADY SHALL go to 1 on the first ACLK edge after ARESETn deasserts; request ready signals SHALL be 1 on that same edge.

Configuration
REQ-019 With AXI4L_MGR_TIMEOUT_EN defined, each engine SHALL run a watchdog counter that increments while its cnt>0 and clears on a response; when it reaches TIMEOUT_CYC, timeout_err SHALL set (sticky) and the counter SHALL hold.
REQ-020 Without AXI4L_MGR_TIMEOUT_EN, the port timeout_err SHALL be absent and no watchdog logic SHALL exist.

Verification
REQ-021 Single write 0x10/0xDEADBEEF/0xF with AWREADY=WREADY=1 -> AWVALID and WVALID high for 1 cycle; BRESP=00 -> wr_rsp_valid pulse, resp=00.
REQ-022 WREADY delayed 3 cycles after AWREADY -> WDATA stable, wr_req_ready=0 until W handshake.
REQ-023 MAX_OUT=4, issue 5 reads with no R -> 4 accepted, rd_req_ready=0; one R of 0xA5 -> rd_rsp_data=0xA5, 5th read accepted.
REQ-024 Unsolicited BVALID with wr_cnt=0 -> no wr_rsp_valid, proto_err=1 until reset.
REQ-025 TIMEOUT_CYC=16, macro defined, read with no R -> timeout_err=1 at cycle 16; assert ARESETn=0 mid-flight -> all outputs at reset values.
